// File: rtl/cache_line_store_pkg.sv
// cache_pkg: shared byte width, refill state encoding and line-size helper for cache_line_store
package cache_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, FILL, DONE} refill_state_t;
  function automatic int line_words(input int offset_w);
    return 1 << offset_w;
  endfunction
endpackage

// File: rtl/cache_line_store_word_bank.sv
// cache_word_bank: byte-masked one-write/one-sync-read word array; CACHE_LINE_STORE_FWD_EN selects write-first reads
module cache_word_bank
  import cache_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_W/BYTE_W-1:0] we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [WORD_W-1:0]        rdata
);
  localparam int NB = WORD_W / BYTE_W;
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_word;
  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++)
      if (we[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
`ifdef CACHE_LINE_STORE_FWD_EN
  logic [WORD_W-1:0] merged;
  always_comb begin
    merged = mem[waddr];
    for (int i = 0; i < NB; i++)
      if (we[i]) merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
  end
  assign rd_word = (|we && waddr == raddr) ? merged : mem[raddr];
`else
  assign rd_word = mem[raddr];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= rd_word;
endmodule

// File: rtl/cache_line_store.sv
// cache_line_store: cache data array with byte-masked CPU port and line-refill engine (option CACHE_LINE_STORE_FWD_EN)
module cache_line_store
  import cache_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INDEX_W+OFFSET_W-1:0] cpu_addr,
  input  logic                        cpu_rd_en,
  output logic [WORD_W-1:0]           cpu_rd_data,
  input  logic                        cpu_wr_en,
  input  logic [WORD_W/8-1:0]         cpu_byte_en,
  input  logic [WORD_W-1:0]           cpu_wr_data,
  input  logic                        refill_start,
  input  logic [INDEX_W-1:0]          refill_index,
  input  logic                        refill_valid,
  input  logic [WORD_W-1:0]           refill_data,
  output logic                        refill_ready,
  output logic                        refill_busy,
  output logic                        refill_done
);
  localparam int LINE_WORDS = line_words(OFFSET_W);
  localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'(LINE_WORDS - 1);
  localparam int NB = WORD_W / BYTE_W;
  refill_state_t state, state_nx;
  logic [OFFSET_W-1:0] cnt;
  logic [INDEX_W-1:0] idx;
  logic beat;
  logic [NB-1:0] we;
  logic [INDEX_W+OFFSET_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && refill_start) begin
        idx <= refill_index;
        cnt <= '0;
      end else if (beat) cnt <= cnt + 1'b1;
    end
  always_comb begin
    state_nx = state;
    refill_ready = state == FILL;
    refill_busy = state != IDLE;
    refill_done = state == DONE;
    beat = refill_valid && refill_ready;
    case (state)
      IDLE: state_nx = refill_start ? FILL : IDLE;
      FILL: state_nx = (beat && cnt == LAST) ? DONE : FILL;
      default: state_nx = IDLE;
    endcase
  end
  // refill owns the write port for the whole busy window; CPU writes then drop
  assign we = beat ? {NB{1'b1}} : (cpu_wr_en && !refill_busy) ? cpu_byte_en : '0;
  assign waddr = beat ? {idx, cnt} : cpu_addr;
  assign wdata = beat ? refill_data : cpu_wr_data;
  cache_word_bank #(.WORD_W(WORD_W), .ADDR_W(INDEX_W + OFFSET_W)) u_bank (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re(cpu_rd_en),
    .raddr(cpu_addr),
    .rdata(cpu_rd_data)
  );
endmodule

// File: tb/tb_cache_line_store.sv
// tb_cache_line_store: directed self-checking bench for cache_line_store
module tb_cache_line_store;
  logic clk = 0;
  logic rst = 1;
  logic [6:0] cpu_addr = '0;
  logic cpu_rd_en = 0;
  logic [31:0] cpu_rd_data;
  logic cpu_wr_en = 0;
  logic [3:0] cpu_byte_en = '0;
  logic [31:0] cpu_wr_data = '0;
  logic refill_start = 0;
  logic [4:0] refill_index = '0;
  logic refill_valid = 0;
  logic [31:0] refill_data = '0;
  logic refill_ready, refill_busy, refill_done;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cache_line_store dut (
    .clk(clk),
    .rst(rst),
    .cpu_addr(cpu_addr),
    .cpu_rd_en(cpu_rd_en),
    .cpu_rd_data(cpu_rd_data),
    .cpu_wr_en(cpu_wr_en),
    .cpu_byte_en(cpu_byte_en),
    .cpu_wr_data(cpu_wr_data),
    .refill_start(refill_start),
    .refill_index(refill_index),
    .refill_valid(refill_valid),
    .refill_data(refill_data),
    .refill_ready(refill_ready),
    .refill_busy(refill_busy),
    .refill_done(refill_done)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_addr = a;
    cpu_wr_data = d;
    cpu_byte_en = be;
    cpu_wr_en = 1;
    tick();
    cpu_wr_en = 0;
  endtask
  task automatic read_word(input logic [6:0] a, output logic [31:0] d);
    cpu_addr = a;
    cpu_rd_en = 1;
    tick();
    cpu_rd_en = 0;
    d = cpu_rd_data;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++; if (cpu_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected %h", cpu_rd_data, 32'h0); end
    checks++; if (refill_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", refill_ready); end
    checks++; if (refill_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", refill_busy); end
    checks++; if (refill_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", refill_done); end
    rst = 0;
    tick();
  endtask
  task automatic test_byte_write();
    logic [31:0] d;
    cpu_write(7'h05, 32'h11223344, 4'hF);
    cpu_write(7'h05, 32'hAABBCCDD, 4'b0101);
    read_word(7'h05, d);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL byte_mask: got %h expected %h", d, 32'h11BB33DD); end
    cpu_write(7'h05, 32'hFFFFFFFF, 4'b0000);
    read_word(7'h05, d);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL byte_en_zero: got %h expected %h", d, 32'h11BB33DD); end
    cpu_addr = 7'h06;
    tick();
    checks++; if (cpu_rd_data !== 32'h11BB33DD) begin errors++; $display("FAIL rd_hold: got %h expected %h", cpu_rd_data, 32'h11BB33DD); end
    cpu_write(7'h05, 32'h55667788, 4'b1010);
    read_word(7'h05, d);
    checks++; if (d !== 32'h55BB77DD) begin errors++; $display("FAIL byte_mask_hi: got %h expected %h", d, 32'h55BB77DD); end
  endtask
  task automatic test_refill_no_stall();
    logic [31:0] d;
    int rdy = 0;
    bit early = 0;
    refill_index = 5'h03;
    refill_start = 1;
    tick();
    refill_start = 0;
    for (int i = 0; i < 4; i++) begin
      refill_valid = 1;
      refill_data = 32'h100 + i;
      if (refill_ready === 1'b1) rdy++;
      if (refill_done !== 1'b0) early = 1;
      tick();
    end
    refill_valid = 0;
    checks++; if (rdy != 4) begin errors++; $display("FAIL ready_cycles: got %0d expected 4", rdy); end
    checks++; if (early) begin errors++; $display("FAIL done_early: got 1 expected 0"); end
    checks++; if (refill_done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b expected 1", refill_done); end
    checks++; if (refill_ready !== 1'b0) begin errors++; $display("FAIL ready_in_done: got %b expected 0", refill_ready); end
    checks++; if (refill_busy !== 1'b1) begin errors++; $display("FAIL busy_in_done: got %b expected 1", refill_busy); end
    refill_start = 1;
    refill_index = 5'h07;
    tick();
    refill_start = 0;
    checks++; if (refill_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", refill_done); end
    checks++; if (refill_busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy got %b expected 0", refill_busy); end
    for (int i = 0; i < 4; i++) begin
      read_word(7'h0C + 7'(i), d);
      checks++; if (d !== 32'h100 + i) begin errors++; $display("FAIL refill_word%0d: got %h expected %h", i, d, 32'h100 + i); end
    end
  endtask
  task automatic test_stall_and_blocked();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) cpu_write(7'h1C + 7'(i), 32'h700 + i, 4'hF);
    refill_index = 5'h03;
    refill_start = 1;
    tick();
    refill_start = 0;
    for (int i = 0; i < 2; i++) begin
      refill_valid = 1;
      refill_data = 32'h200 + i;
      tick();
    end
    refill_valid = 0;
    refill_data = 32'hBAD0BAD0;
    cpu_addr = 7'h0C;
    cpu_wr_data = 32'hDEADBEEF;
    cpu_byte_en = 4'hF;
    cpu_wr_en = 1;
    refill_index = 5'h07;
    refill_start = 1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (refill_ready !== 1'b1) begin errors++; $display("FAIL stall_ready%0d: got %b expected 1", i, refill_ready); end
      checks++; if (refill_done !== 1'b0) begin errors++; $display("FAIL stall_done%0d: got %b expected 0", i, refill_done); end
      tick();
      cpu_wr_en = 0;
      refill_start = 0;
    end
    for (int i = 2; i < 4; i++) begin
      refill_valid = 1;
      refill_data = 32'h200 + i;
      checks++; if (refill_done !== 1'b0) begin errors++; $display("FAIL stall_done_beat%0d: got %b expected 0", i, refill_done); end
      tick();
    end
    refill_valid = 0;
    checks++; if (refill_done !== 1'b1) begin errors++; $display("FAIL stall_done_final: got %b expected 1", refill_done); end
    tick();
    for (int i = 0; i < 4; i++) begin
      read_word(7'h0C + 7'(i), d);
      checks++; if (d !== 32'h200 + i) begin errors++; $display("FAIL stall_word%0d: got %h expected %h", i, d, 32'h200 + i); end
    end
    for (int i = 0; i < 4; i++) begin
      read_word(7'h1C + 7'(i), d);
      checks++; if (d !== 32'h700 + i) begin errors++; $display("FAIL line7_word%0d: got %h expected %h", i, d, 32'h700 + i); end
    end
  endtask
  task automatic test_reset_mid_fill();
    logic [31:0] d;
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) cpu_write(7'h24 + 7'(i), 32'h900 + i, 4'hF);
    refill_index = 5'h09;
    refill_start = 1;
    tick();
    refill_start = 0;
    for (int i = 0; i < 2; i++) begin
      refill_valid = 1;
      refill_data = 32'hA00 + i;
      tick();
    end
    refill_valid = 0;
    rst = 1;
    #1;
    checks++; if (refill_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", refill_busy); end
    checks++; if (refill_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", refill_ready); end
    tick();
    rst = 0;
    tick();
    checks++; if (refill_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", refill_done); end
    for (int i = 0; i < 4; i++) begin
      exp = (i < 2) ? 32'hA00 + i : 32'h900 + i;
      read_word(7'h24 + 7'(i), d);
      checks++; if (d !== exp) begin errors++; $display("FAIL midreset_word%0d: got %h expected %h", i, d, exp); end
    end
  endtask
  task automatic test_same_cycle();
    logic [31:0] d;
    logic [31:0] exp;
`ifdef CACHE_LINE_STORE_FWD_EN
    exp = 32'hFFFFFFFF;
`else
    exp = 32'h0;
`endif
    cpu_write(7'h20, 32'h0, 4'hF);
    cpu_addr = 7'h20;
    cpu_wr_data = 32'hFFFFFFFF;
    cpu_byte_en = 4'hF;
    cpu_wr_en = 1;
    cpu_rd_en = 1;
    tick();
    cpu_wr_en = 0;
    cpu_rd_en = 0;
    checks++; if (cpu_rd_data !== exp) begin errors++; $display("FAIL same_cycle_rw: got %h expected %h", cpu_rd_data, exp); end
    read_word(7'h20, d);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL after_rw: got %h expected %h", d, 32'hFFFFFFFF); end
  endtask
  initial begin
    test_reset();
    test_byte_write();
    test_refill_no_stall();
    test_stall_and_blocked();
    test_reset_mid_fill();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
